vga_rx_capture: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: samples hsync/vsync/rgb
//  of a 640x480@60 stream, checks them against the expected mode and locks after

---
 rtl/vga_rx_capture.sv | 173 +++++++++++++++++
 tb/tb_vga_rx_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_capture.sv
// rtl/vga_rx_capture.sv - VGA receive-side timing checker, lock FSM and pixel capture
// Samples a looped-back VGA stream, locks onto the expected mode and recovers x/y/de/colour.
module vga_rx_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [11:0] vga_rgb,
  output logic        lock,
  output logic        pix_de,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic        lock_lost,
  output logic [10:0] h_total,
  output logic [10:0] v_total
);

  localparam logic [10:0] HT     = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] VT     = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] X0     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] Y0     = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] XN     = 11'(H_ACTIVE);
  localparam logic [10:0] YN     = 11'(V_ACTIVE);
  localparam logic [6:0]  HSW    = 7'(H_SYNC);
  localparam logic [3:0]  LF     = 4'(LOCK_FRAMES);
  localparam logic [10:0] CNT_MAX = 11'h7ff;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  goodcnt, goodcnt_nx;
  logic [2:0]  hs_sr, vs_sr;
  logic [11:0] rgb_s1, rgb_s2, rgb_s3;
  logic [10:0] hcnt, vcnt;
  logic [6:0]  hsw;
  logic        frame_bad;

  logic        hs_rise, hs_fall, vs_rise, timeout;
  logic        line_bad, hsw_bad, over, frame_ok;
  logic [10:0] frame_len, x_full, y_full;
  logic        de_nx;

  // Edges are taken between the second and third sync stages (already normalised to 1 = asserted).
  assign hs_rise   = hs_sr[1] & ~hs_sr[2];
  assign hs_fall   = ~hs_sr[1] & hs_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign timeout   = (hcnt == CNT_MAX) & ~hs_rise;
  assign line_bad  = hs_rise & (({1'b0, hcnt} + 12'd1) != {1'b0, HT});
  assign hsw_bad   = hs_fall & (hsw != HSW);
  assign over      = hs_rise & ~vs_rise & (vcnt >= VT);
  assign frame_len = hs_rise ? vcnt + 11'd1 : vcnt;
  assign frame_ok  = ~frame_bad & ~line_bad & ~hsw_bad & ~over & (frame_len == VT);
  assign x_full    = hcnt - X0;
  assign y_full    = vcnt - Y0;
  assign de_nx     = (state_nx == LOCKED) & (x_full < XN) & (y_full < YN);

  always_comb begin
    state_nx   = state;
    goodcnt_nx = goodcnt;
    if (pix_ce) begin
      if (timeout) begin
        state_nx = SEARCH;
      end else begin
        case (state)
          SEARCH: if (vs_rise) begin
            state_nx   = MEASURE;
            goodcnt_nx = 4'd0;
          end
          MEASURE: if (vs_rise) begin
            if (frame_ok) begin
              goodcnt_nx = goodcnt + 4'd1;
              if (goodcnt + 4'd1 == LF) state_nx = LOCKED;
            end else begin
              goodcnt_nx = 4'd0;
            end
          end
          LOCKED: if (line_bad | hsw_bad | over | (vs_rise & ~frame_ok)) state_nx = SEARCH;
          default: state_nx = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= SEARCH;
      goodcnt <= 4'd0;
    end else begin
      state   <= state_nx;
      goodcnt <= goodcnt_nx;
    end
  end

  // After each strobe hcnt/vcnt describe the pixel held in the third stage.
  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n) begin
      hs_sr     <= 3'b000;
      vs_sr     <= 3'b000;
      rgb_s1    <= 12'd0;
      rgb_s2    <= 12'd0;
      rgb_s3    <= 12'd0;
      hcnt      <= 11'd0;
      vcnt      <= 11'd0;
      hsw       <= 7'd0;
      frame_bad <= 1'b0;
      h_total   <= 11'd0;
      v_total   <= 11'd0;
    end else if (pix_ce) begin
      hs_sr  <= {hs_sr[1:0], vga_hsync == SYNC_POL};
      vs_sr  <= {vs_sr[1:0], vga_vsync == SYNC_POL};
      rgb_s1 <= vga_rgb;
      rgb_s2 <= rgb_s1;
      rgb_s3 <= rgb_s2;
      if (hs_rise) begin
        h_total <= (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 11'd1;
        hcnt    <= 11'd0;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + 11'd1;
      end
      if (hs_rise) hsw <= 7'd1;
      else if (hs_sr[1] && hsw != 7'h7f) hsw <= hsw + 7'd1;
      if (vs_rise) begin
        v_total   <= frame_len;
        vcnt      <= 11'd0;
        frame_bad <= 1'b0;
      end else begin
        if (hs_rise) vcnt <= vcnt + 11'd1;
        if (line_bad | hsw_bad | over | timeout) frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n) begin
      lock        <= 1'b0;
      pix_de      <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_data    <= 12'd0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
      if (pix_ce) begin
        lock        <= (state_nx == LOCKED);
        lock_lost   <= (state == LOCKED) && (state_nx != LOCKED);
        frame_start <= (state == LOCKED) && (state_nx == LOCKED) && vs_rise;
        pix_de      <= de_nx;
        pix_data    <= de_nx ? rgb_s3 : 12'd0;
        if (de_nx) begin
          pix_x <= x_full[9:0];
          pix_y <= y_full[9:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// tb/tb_vga_rx_capture.sv - scoreboard bench for vga_rx_capture on a reduced-size video mode
// Two instances run in parallel: active-low syncs and inverted syncs with SYNC_POL=1.
module tb_vga_rx_capture;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        sys_clk, rst_n, pix_ce;
  logic        hs_a, vs_a;
  logic [11:0] rgb;

  logic        lock_o [2];
  logic        de_o   [2];
  logic [9:0]  px_o   [2];
  logic [9:0]  py_o   [2];
  logic [11:0] pd_o   [2];
  logic        fs_o   [2];
  logic        ll_o   [2];
  logic [10:0] ht_o   [2];
  logic [10:0] vt_o   [2];

  int checks = 0, errors = 0;
  int de_cnt [2] = '{0, 0};
  int fs_cnt [2] = '{0, 0};
  int ll_cnt [2] = '{0, 0};
  logic [31:0] expq [$];

  vga_rx_capture #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .vga_hsync(~hs_a), .vga_vsync(~vs_a), .vga_rgb(rgb),
    .lock(lock_o[0]), .pix_de(de_o[0]), .pix_x(px_o[0]), .pix_y(py_o[0]),
    .pix_data(pd_o[0]), .frame_start(fs_o[0]), .lock_lost(ll_o[0]),
    .h_total(ht_o[0]), .v_total(vt_o[0]));

  vga_rx_capture #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_rgb(rgb),
    .lock(lock_o[1]), .pix_de(de_o[1]), .pix_x(px_o[1]), .pix_y(py_o[1]),
    .pix_data(pd_o[1]), .frame_start(fs_o[1]), .lock_lost(ll_o[1]),
    .h_total(ht_o[1]), .v_total(vt_o[1]));

  initial begin
    sys_clk = 1'b0;
    pix_ce  = 1'b0;
    forever begin
      #10 sys_clk = 1'b1;
      #10 sys_clk = 1'b0;
      pix_ce = ~pix_ce;
    end
  end

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual %h required %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pat(input int x, input int y);
    return 12'((x ^ y) | (x << 4) | (y << 8));
  endfunction

  // Monitor: pops the scoreboard whenever either instance presents an active pixel.
  initial begin
    logic        ce_seen;
    logic [31:0] e;
    forever begin
      @(posedge sys_clk);
      ce_seen = pix_ce;
      @(negedge sys_clk);
      for (int i = 0; i < 2; i++) begin
        if (ll_o[i]) ll_cnt[i]++;
        if (fs_o[i]) fs_cnt[i]++;
      end
      if (ce_seen) begin
        if (de_o[0] || de_o[1]) begin
          if (expq.size() == 0) begin
            chk("unexpected_de", 0, {63'd0, de_o[0] | de_o[1]}, 64'd0);
          end else begin
            e = expq.pop_front();
            for (int i = 0; i < 2; i++)
              chk("pixel", i, {31'd0, de_o[i], px_o[i], py_o[i], pd_o[i]}, {31'd0, 1'b1, e});
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (de_o[i]) de_cnt[i]++;
          else chk("data_zero", i, {52'd0, pd_o[i]}, 64'd0);
        end
      end
    end
  end

  task automatic pixel(input bit hs, input bit vs, input logic [11:0] c);
    do @(posedge sys_clk); while (!pix_ce);
    #2;
    hs_a = hs;
    vs_a = vs;
    rgb  = c;
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", i,
          {6'd0, lock_o[i], de_o[i], px_o[i], py_o[i], pd_o[i], fs_o[i], ll_o[i], ht_o[i], vt_o[i]}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs();
    @(posedge sys_clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic send_frame(input bit exp_de, input int nlines, input int short_line, input int rst_line);
    for (int v = 0; v < nlines; v++) begin
      int len;
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        int x, y;
        bit act;
        logic [11:0] c;
        x   = h - (HS + HB);
        y   = v - (VS + VB);
        act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
        c   = act ? pat(x, y) : 12'hA5A;
        if (v == rst_line && h == 5) do_reset();
        pixel(h < HS, v < VS, c);
        if (act && exp_de) expq.push_back({10'(x), 10'(y), c});
      end
    end
  endtask

  task automatic chk_both(input string name, input int which, input int exp);
    for (int i = 0; i < 2; i++) begin
      case (which)
        0: chk(name, i, {63'd0, lock_o[i]}, 64'(exp));
        1: chk(name, i, {53'd0, ht_o[i]}, 64'(exp));
        2: chk(name, i, {53'd0, vt_o[i]}, 64'(exp));
        3: chk(name, i, 64'(de_cnt[i]), 64'(exp));
        4: chk(name, i, 64'(ll_cnt[i]), 64'(exp));
        5: chk(name, i, 64'(fs_cnt[i]), 64'(exp));
        default: chk(name, i, {63'd0, de_o[i]}, 64'(exp));
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    hs_a  = 1'b0;
    vs_a  = 1'b0;
    rgb   = 12'd0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs();
    @(posedge sys_clk);
    #2 rst_n = 1'b0;

    send_frame(0, VT, -1, -1);
    send_frame(0, VT, -1, -1);
    chk_both("no_lock_before_3rd_vsync", 0, 0);
    send_frame(1, VT, -1, -1);
    chk_both("lock_after_3rd_vsync", 0, 1);
    chk_both("h_total", 1, HT);
    chk_both("v_total", 2, VT);
    chk_both("de_per_frame", 3, HA * VA);
    send_frame(1, VT, -1, -1);
    chk_both("frame_start_count", 5, 1);
    chk_both("de_two_frames", 3, 2 * HA * VA);

    send_frame(1, VT, 7, -1);
    chk_both("short_line_lock", 0, 0);
    chk_both("short_line_lock_lost", 4, 1);
    chk_both("short_line_de", 6, 0);
    chk_both("short_line_h_total", 1, HT - 1);
    send_frame(0, VT, -1, -1);
    send_frame(0, VT, -1, -1);
    chk_both("no_lock_during_relock", 0, 0);
    send_frame(1, VT, -1, -1);
    chk_both("relock", 0, 1);
    chk_both("de_after_relock", 3, 4 * HA * VA);

    send_frame(1, VT, -1, -1);
    repeat (2100) pixel(1'b0, 1'b0, 12'h0F0);
    chk_both("timeout_lock", 0, 0);
    chk_both("timeout_lock_lost", 4, 2);
    chk_both("timeout_h_total", 1, HT);

    send_frame(0, VT, -1, -1);
    send_frame(0, VT - 1, -1, -1);
    send_frame(0, VT, -1, -1);
    chk_both("short_frame_v_total", 2, VT - 1);
    chk_both("short_frame_no_lock", 0, 0);
    send_frame(0, VT, -1, -1);
    send_frame(1, VT, -1, -1);
    chk_both("lock_after_short_frame", 0, 1);

    send_frame(1, VT, -1, 7);
    chk_both("reset_no_lock_lost", 4, 2);
    chk_both("reset_lock", 0, 0);
    send_frame(0, VT, -1, -1);
    send_frame(0, VT, -1, -1);
    send_frame(1, VT, -1, -1);
    repeat (4) pixel(1'b1, 1'b1, 12'h000);
    chk_both("final_lock", 0, 1);
    chk_both("final_de_total", 3, 8 * HA * VA);
    chk_both("final_frame_start", 5, 4);
    chk_both("final_lock_lost", 4, 2);
    chk("queue_empty", 0, 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
